// File: rtl/segre_pkg.sv
// Shared I-cache refill types and geometry. Tag and index widths are derived
// here so the tag store, data array and refill handler agree on one layout.
package segre_pkg;

  localparam int ICACHE_ADDR_WIDTH  = 32;
  localparam int ICACHE_LINE_SIZE   = 128;
  localparam int ICACHE_OFFSET_SIZE = $clog2(ICACHE_LINE_SIZE / 8);
  localparam int ICACHE_NUM_LANES   = 4;
  localparam int ICACHE_INDEX_SIZE  = $clog2(ICACHE_NUM_LANES);
  localparam int ICACHE_TAG_SIZE    = ICACHE_ADDR_WIDTH - ICACHE_OFFSET_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } icache_refill_state_t;

endpackage

// File: rtl/segre_icache_victim_sel.sv
// Round-robin victim pointer for the fully-associative I-cache lanes.
// Advances only when a refill actually installs a tag.
module segre_icache_victim_sel
  import segre_pkg::*;
#(
  parameter  int NUM_LANES  = ICACHE_NUM_LANES,
  localparam int INDEX_SIZE = $clog2(NUM_LANES)
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  advance_i,
  output logic [INDEX_SIZE-1:0] victim_o
);

  localparam logic [INDEX_SIZE-1:0] LAST_LANE = INDEX_SIZE'(NUM_LANES - 1);

  logic [INDEX_SIZE-1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (advance_i) begin
      rr_d = (rr_q == LAST_LANE) ? '0 : rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign victim_o = rr_q;

endmodule

// File: rtl/segre_icache_refill.sv
// I-cache miss handler: fetches the missing line, then writes data array and tag
// store in one cycle. Define SEGRE_ICACHE_REFILL_PERF_EN for miss/kill counters.
module segre_icache_refill
  import segre_pkg::*;
#(
  parameter  int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter  int LINE_SIZE  = ICACHE_LINE_SIZE,
  parameter  int NUM_LANES  = ICACHE_NUM_LANES,
  localparam int OFFSET     = $clog2(LINE_SIZE / 8),
  localparam int INDEX_SIZE = $clog2(NUM_LANES),
  localparam int TAG_SIZE   = ADDR_WIDTH - OFFSET
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  miss_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  invalidate_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_valid_i,
  input  logic [LINE_SIZE-1:0]  mem_data_i,
  output logic                  tag_wr_o,
  output logic [INDEX_SIZE-1:0] tag_wr_index_o,
  output logic [TAG_SIZE-1:0]   tag_wr_tag_o,
  output logic                  data_wr_o,
  output logic [INDEX_SIZE-1:0] data_wr_index_o,
  output logic [LINE_SIZE-1:0]  data_wr_line_o,
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
  output logic [31:0]           miss_cnt_o,
  output logic [31:0]           kill_cnt_o,
`endif
  output logic                  busy_o,
  output logic                  refill_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET;

  icache_refill_state_t  state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INDEX_SIZE-1:0] victim_q, victim_d;
  logic [LINE_SIZE-1:0]  line_q, line_d;
  logic                  kill_q, kill_d;
  logic [INDEX_SIZE-1:0] rr_victim;
  logic                  miss_accept;
  logic                  in_write;
  logic                  tag_suppress;

  segre_icache_victim_sel #(
    .NUM_LANES (NUM_LANES)
  ) u_victim_sel (
    .clk_i     (clk_i),
    .rsn_i     (rsn_i),
    .advance_i (tag_wr_o),
    .victim_o  (rr_victim)
  );

  assign miss_accept  = (state_q == IDLE) && miss_i;
  assign in_write     = (state_q == WRITE);
  assign tag_suppress = kill_q | invalidate_i;

  // NOTE: every next-state variable takes its current value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    victim_d = victim_q;
    line_d   = line_q;
    kill_d   = kill_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (miss_i) begin
          addr_d   = addr_i;
          victim_d = rr_victim;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (invalidate_i) kill_d = 1'b1;
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (invalidate_i) kill_d = 1'b1;
        if (mem_valid_i) begin
          line_d  = mem_data_i;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line buffer drives data_wr_line_o directly, so it is reset along
  // with the control state to keep every output at zero out of reset.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      victim_q <= '0;
      line_q   <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      victim_q <= victim_d;
      line_q   <= line_d;
      kill_q   <= kill_d;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign mem_req_o       = (state_q == REQ);
  assign mem_addr_o      = addr_q & LINE_MASK;
  assign tag_wr_o        = in_write && !tag_suppress;
  assign tag_wr_index_o  = victim_q;
  assign tag_wr_tag_o    = addr_q[ADDR_WIDTH-1:OFFSET];
  assign data_wr_o       = in_write;
  assign data_wr_index_o = victim_q;
  assign data_wr_line_o  = line_q;
  assign refill_done_o   = in_write;

`ifdef SEGRE_ICACHE_REFILL_PERF_EN
  logic [31:0] miss_cnt_q, kill_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      miss_cnt_q <= '0;
      kill_cnt_q <= '0;
    end else begin
      if (miss_accept) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (in_write && tag_suppress) kill_cnt_q <= kill_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
  assign kill_cnt_o = kill_cnt_q;
`else
  logic unused_miss_accept;
  assign unused_miss_accept = miss_accept;
`endif

endmodule

// File: tb/tb_segre_icache_refill.sv
// Directed bench for the I-cache refill handler: a vector table for the basic
// refill path plus hand-written sequences for stalls, flushes and resets.
module tb_segre_icache_refill;

  logic         clk_i = 1'b0;
  logic         rsn_i;
  logic         miss_i;
  logic [31:0]  addr_i;
  logic         invalidate_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_valid_i;
  logic [127:0] mem_data_i;
  logic         tag_wr_o;
  logic [1:0]   tag_wr_index_o;
  logic [27:0]  tag_wr_tag_o;
  logic         data_wr_o;
  logic [1:0]   data_wr_index_o;
  logic [127:0] data_wr_line_o;
  logic         busy_o;
  logic         refill_done_o;
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
  logic [31:0]  miss_cnt_o;
  logic [31:0]  kill_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_miss_cnt = 0;
  int exp_kill_cnt = 0;

  always #5 clk_i = ~clk_i;

  segre_icache_refill dut (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .miss_i          (miss_i),
    .addr_i          (addr_i),
    .invalidate_i    (invalidate_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_valid_i     (mem_valid_i),
    .mem_data_i      (mem_data_i),
    .tag_wr_o        (tag_wr_o),
    .tag_wr_index_o  (tag_wr_index_o),
    .tag_wr_tag_o    (tag_wr_tag_o),
    .data_wr_o       (data_wr_o),
    .data_wr_index_o (data_wr_index_o),
    .data_wr_line_o  (data_wr_line_o),
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    .miss_cnt_o      (miss_cnt_o),
    .kill_cnt_o      (kill_cnt_o),
`endif
    .busy_o          (busy_o),
    .refill_done_o   (refill_done_o)
  );

  typedef struct {
    logic         miss;
    logic [31:0]  addr;
    logic         gnt;
    logic         valid;
    logic [127:0] data;
    logic         busy;
    logic         req;
    logic [31:0]  maddr;
    logic         tag_wr;
    logic         data_wr;
    logic [1:0]   idx;
    logic [27:0]  tag;
    logic [127:0] line;
    logic         done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    miss_i       = 1'b0;
    addr_i       = '0;
    invalidate_i = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_valid_i  = 1'b0;
    mem_data_i   = '0;
  endtask

  task automatic do_reset();
    rsn_i = 1'b0;
    idle_inputs();
    tick();
    tick();
    rsn_i = 1'b1;
    exp_miss_cnt = 0;
    exp_kill_cnt = 0;
  endtask

  task automatic check_counters(input string name);
`ifdef SEGRE_ICACHE_REFILL_PERF_EN
    check({name, "_miss_cnt"}, 128'(miss_cnt_o), 128'(exp_miss_cnt));
    check({name, "_kill_cnt"}, 128'(kill_cnt_o), 128'(exp_kill_cnt));
`else
    check({name, "_busy_idle"}, 128'(busy_o), 128'(0));
`endif
  endtask

  // One full refill starting in IDLE. gnt_wait cycles of stalled grant (with a
  // stray miss in the middle), optional flush pulse while waiting for data.
  task automatic refill(input string name, input logic [31:0] a, input int gnt_wait,
                        input bit inval, input logic [1:0] exp_idx, input logic [127:0] line);
    logic [31:0] aligned;
    aligned = a & 32'hFFFF_FFF0;
    miss_i = 1'b1;
    addr_i = a;
    tick();
    miss_i = 1'b0;
    exp_miss_cnt++;
    for (int i = 0; i < gnt_wait; i++) begin
      if (i == gnt_wait / 2) begin
        miss_i = 1'b1;
        addr_i = ~a;
      end else begin
        miss_i = 1'b0;
      end
      #1;
      check({name, "_hold_req"}, 128'(mem_req_o), 128'(1));
      check({name, "_hold_addr"}, 128'(mem_addr_o), 128'(aligned));
      check({name, "_hold_busy"}, 128'(busy_o), 128'(1));
      tick();
    end
    miss_i    = 1'b0;
    mem_gnt_i = 1'b1;
    check({name, "_req"}, 128'(mem_req_o), 128'(1));
    tick();
    mem_gnt_i = 1'b0;
    if (inval) begin
      invalidate_i = 1'b1;
      tick();
      invalidate_i = 1'b0;
      exp_kill_cnt++;
    end
    mem_valid_i = 1'b1;
    mem_data_i  = line;
    tick();
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    check({name, "_data_wr"}, 128'(data_wr_o), 128'(1));
    check({name, "_tag_wr"}, 128'(tag_wr_o), 128'(!inval));
    check({name, "_done"}, 128'(refill_done_o), 128'(1));
    check({name, "_data_idx"}, 128'(data_wr_index_o), 128'(exp_idx));
    check({name, "_tag_idx"}, 128'(tag_wr_index_o), 128'(exp_idx));
    check({name, "_tag"}, 128'(tag_wr_tag_o), 128'(a[31:4]));
    check({name, "_line"}, data_wr_line_o, line);
    tick();
    check({name, "_done_clr"}, 128'(refill_done_o), 128'(0));
    check({name, "_busy_clr"}, 128'(busy_o), 128'(0));
    check_counters(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5, p11, p22;
    a5  = {16{8'hA5}};
    p11 = {16{8'h11}};
    p22 = {16{8'h22}};
    //        miss addr          gnt  val  data   busy req maddr         tw   dw   idx   tag         line  done
    vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, '0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 2'd0, 28'h0,       '0,  1'b0};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, '0,  1'b1, 1'b1, 32'h0000_1230, 1'b0, 1'b0, 2'd0, 28'h0000123, '0,  1'b0};
    vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b1, a5,  1'b1, 1'b0, 32'h0000_1230, 1'b0, 1'b0, 2'd0, 28'h0000123, '0,  1'b0};
    vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b0, '0,  1'b1, 1'b0, 32'h0000_1230, 1'b1, 1'b1, 2'd0, 28'h0000123, a5,  1'b1};
    vecs[4] = '{1'b1, 32'h0000_2008, 1'b0, 1'b0, '0,  1'b0, 1'b0, 32'h0000_1230, 1'b0, 1'b0, 2'd0, 28'h0000123, a5,  1'b0};
    vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b1, p11, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 2'd1, 28'h0000200, a5,  1'b0};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, '0,  1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 2'd1, 28'h0000200, a5,  1'b0};
    vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b0, '0,  1'b1, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 2'd1, 28'h0000200, a5,  1'b0};
    vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b1, p22, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 2'd1, 28'h0000200, a5,  1'b0};
    vecs[9] = '{1'b0, 32'h0,         1'b0, 1'b0, '0,  1'b1, 1'b0, 32'h0000_2000, 1'b1, 1'b1, 2'd1, 28'h0000200, p22, 1'b1};

    do_reset();
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_req", 128'(mem_req_o), 128'(0));
    check("rst_done", 128'(refill_done_o), 128'(0));
    check("rst_tag_wr", 128'(tag_wr_o), 128'(0));
    check("rst_data_wr", 128'(data_wr_o), 128'(0));

    // Basic refill, then a refill with an early mem_valid_i while still in REQ.
    for (int i = 0; i < 10; i++) begin
      miss_i      = vecs[i].miss;
      addr_i      = vecs[i].addr;
      mem_gnt_i   = vecs[i].gnt;
      mem_valid_i = vecs[i].valid;
      mem_data_i  = vecs[i].data;
      #1;
      check($sformatf("vec%0d_busy", i), 128'(busy_o), 128'(vecs[i].busy));
      check($sformatf("vec%0d_req", i), 128'(mem_req_o), 128'(vecs[i].req));
      check($sformatf("vec%0d_maddr", i), 128'(mem_addr_o), 128'(vecs[i].maddr));
      check($sformatf("vec%0d_tag_wr", i), 128'(tag_wr_o), 128'(vecs[i].tag_wr));
      check($sformatf("vec%0d_data_wr", i), 128'(data_wr_o), 128'(vecs[i].data_wr));
      check($sformatf("vec%0d_idx", i), 128'(tag_wr_index_o), 128'(vecs[i].idx));
      check($sformatf("vec%0d_tag", i), 128'(tag_wr_tag_o), 128'(vecs[i].tag));
      check($sformatf("vec%0d_line", i), data_wr_line_o, vecs[i].line);
      check($sformatf("vec%0d_done", i), 128'(refill_done_o), 128'(vecs[i].done));
      tick();
    end
    idle_inputs();
    tick();

    // Back-to-back refills walk the victim pointer 0,1,2,3 and wrap to 0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      refill($sformatf("b2b%0d", i), 32'h0001_0000 + 32'(i) * 32'h40 + 32'h4,
             0, 1'b0, 2'(i), {4{32'hC0DE_0000 + 32'(i)}});
    end

    // Grant stalled 10 cycles with a stray miss in the middle; victim 1.
    refill("hold", 32'h8765_4328, 10, 1'b0, 2'd1, {4{32'hDEAD_BEEF}});

    // Flush while waiting for data: data written, tag suppressed, pointer held.
    refill("inval", 32'h0000_3000, 0, 1'b1, 2'd2, {4{32'h1234_5678}});
    refill("after_inval", 32'h0000_4000, 0, 1'b0, 2'd2, {4{32'h0F0F_0F0F}});

    // Reset while in WAIT: late data ignored, pointer back to lane 0.
    miss_i = 1'b1;
    addr_i = 32'h0000_5000;
    tick();
    miss_i    = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    check("rstw_in_wait_busy", 128'(busy_o), 128'(1));
    rsn_i = 1'b0;
    tick();
    rsn_i = 1'b1;
    exp_miss_cnt = 0;
    exp_kill_cnt = 0;
    mem_valid_i  = 1'b1;
    mem_data_i   = {4{32'hBAD0_BAD0}};
    #1;
    check("rstw_busy", 128'(busy_o), 128'(0));
    check("rstw_data_wr", 128'(data_wr_o), 128'(0));
    tick();
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    check("rstw_busy2", 128'(busy_o), 128'(0));
    check("rstw_data_wr2", 128'(data_wr_o), 128'(0));
    check("rstw_tag_wr2", 128'(tag_wr_o), 128'(0));
    check("rstw_done2", 128'(refill_done_o), 128'(0));
    check_counters("rstw");
    refill("post_rst", 32'h0000_6000, 0, 1'b0, 2'd0, {4{32'h5555_AAAA}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
